// File: rtl/mc_bus_bridge.sv
// Bridge from an asynchronous active-low MCU strobe bus to a config register file,
// a command FIFO write port and a first-word-fall-through response FIFO read port.
module mc_bus_bridge #(
  parameter int MC_DATA_WIDTH = 16,
  parameter int MC_ADD_WIDTH  = 6
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       mc_ce,
  input  logic                       mc_we,
  input  logic                       mc_oe,
  input  logic [MC_ADD_WIDTH-1:0]    mc_add,
  input  logic [MC_DATA_WIDTH-1:0]   mc_data_in,
  output logic [MC_DATA_WIDTH-1:0]   mc_data_out,
  output logic                       mc_data_oe,
  output logic [7*MC_DATA_WIDTH-1:0] cfg_regs,
  output logic                       ctrl_wr_strobe,
  output logic [MC_DATA_WIDTH-1:0]   cmd_data,
  output logic                       cmd_push,
  input  logic                       cmd_full,
  input  logic [MC_DATA_WIDTH-1:0]   rsp_data,
  output logic                       rsp_pop,
  input  logic                       rsp_empty,
  input  logic                       bp_active
);

  localparam int NUM_REGS = 7;
  localparam logic [MC_ADD_WIDTH-1:0] A_CTRL = MC_ADD_WIDTH'(3);
  localparam logic [MC_ADD_WIDTH-1:0] A_CMD  = MC_ADD_WIDTH'(7);
  localparam logic [MC_ADD_WIDTH-1:0] A_STAT = MC_ADD_WIDTH'(8);

  typedef enum logic [1:0] {IDLE, WR_HOLD, RD_HOLD} state_e;

  // Bit order {oe, we, ce}; zero on reset so a strobe held low through reset looks idle
  logic [2:0] pins;
  logic [2:0] sync1_q, sync2_q, dly_q;
  logic       ce_s, we_s, oe_s, we_fall, oe_fall;

  state_e state_q, state_d;
  logic   wr_act, rd_act, rd_done;

  logic [NUM_REGS-1:0][MC_DATA_WIDTH-1:0] regs_q, regs_d;
  logic [MC_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [MC_DATA_WIDTH-1:0] cmd_data_q, cmd_data_d;
  logic [MC_DATA_WIDTH-1:0] status;
  logic cmd_push_q, cmd_push_d;
  logic rsp_pop_q, rsp_pop_d;
  logic strobe_q, strobe_d;
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic rd_stat_q, rd_stat_d;
  logic ovf_set, unf_set;

  assign pins       = {mc_oe, mc_we, mc_ce};
  assign mc_data_oe = !mc_oe && !mc_ce;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      dly_q   <= '0;
    end else begin
      sync1_q <= pins;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
    end
  end

  assign ce_s    = sync2_q[0];
  assign we_s    = sync2_q[1];
  assign oe_s    = sync2_q[2];
  assign we_fall = dly_q[1] && !sync2_q[1];
  assign oe_fall = dly_q[2] && !sync2_q[2];

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Both strobes low in IDLE matches neither entry condition, so nothing happens
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (we_fall && !ce_s && oe_s)      state_d = WR_HOLD;
        else if (oe_fall && !ce_s && we_s) state_d = RD_HOLD;
      end
      WR_HOLD: if (we_s) state_d = IDLE;
      RD_HOLD: if (oe_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_act  = (state_q == IDLE) && (state_d == WR_HOLD);
    rd_act  = (state_q == IDLE) && (state_d == RD_HOLD);
    rd_done = (state_q == RD_HOLD) && (state_d == IDLE);
  end

  always_comb begin
    status      = '0;
    status[4:0] = {bp_active, unf_q, ovf_q, !rsp_empty, cmd_full};
  end

  always_comb begin
    regs_d     = regs_q;
    rd_data_d  = rd_data_q;
    cmd_data_d = cmd_data_q;
    rd_stat_d  = rd_stat_q;
    cmd_push_d = 1'b0;
    rsp_pop_d  = 1'b0;
    strobe_d   = 1'b0;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;

    if (wr_act) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (mc_add == MC_ADD_WIDTH'(i)) regs_d[i] = mc_data_in;
      if (mc_add == A_CTRL) strobe_d = 1'b1;
      if (mc_add == A_CMD) begin
        if (!cmd_full) begin
          cmd_data_d = mc_data_in;
          cmd_push_d = 1'b1;
        end else begin
          ovf_set = 1'b1;
        end
      end
    end

    if (rd_act) begin
      rd_data_d = '0;
      rd_stat_d = (mc_add == A_STAT);
      for (int i = 0; i < NUM_REGS; i++)
        if (mc_add == MC_ADD_WIDTH'(i)) rd_data_d = regs_q[i];
      if (mc_add == A_CMD) begin
        if (!rsp_empty) begin
          rd_data_d = rsp_data;
          rsp_pop_d = 1'b1;
        end else begin
          unf_set = 1'b1;
        end
      end
      if (mc_add == A_STAT) rd_data_d = status;
    end

    // Sticky flags: a set on the same edge wins over the status-read clear
    if (ovf_set)                 ovf_d = 1'b1;
    else if (rd_done && rd_stat_q) ovf_d = 1'b0;
    else                         ovf_d = ovf_q;

    if (unf_set)                 unf_d = 1'b1;
    else if (rd_done && rd_stat_q) unf_d = 1'b0;
    else                         unf_d = unf_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      regs_q     <= '0;
      rd_data_q  <= '0;
      cmd_data_q <= '0;
      rd_stat_q  <= 1'b0;
      cmd_push_q <= 1'b0;
      rsp_pop_q  <= 1'b0;
      strobe_q   <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      rd_data_q  <= rd_data_d;
      cmd_data_q <= cmd_data_d;
      rd_stat_q  <= rd_stat_d;
      cmd_push_q <= cmd_push_d;
      rsp_pop_q  <= rsp_pop_d;
      strobe_q   <= strobe_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign cfg_regs       = regs_q;
  assign mc_data_out    = rd_data_q;
  assign cmd_data       = cmd_data_q;
  assign cmd_push       = cmd_push_q;
  assign rsp_pop        = rsp_pop_q;
  assign ctrl_wr_strobe = strobe_q;

endmodule

// File: doc/mc_bus_bridge.md
MC_BUS_BRIDGE -- requirements
Module: mc_bus_bridge

Interface
REQ-001 Parameter MC_DATA_WIDTH, default 16, MCU data bus width.
REQ-002 Parameter MC_ADD_WIDTH, default 6, MCU address bus width.
REQ-003 clock  in  1  single system clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 mc_ce, mc_we, mc_oe  in  1 each  asynchronous MCU strobes, active low.
REQ-006 mc_add  in  MC_ADD_WIDTH  MCU address.
REQ-007 mc_data_in  in  MC_DATA_WIDTH  MCU write data.
REQ-008 mc_data_out  out  MC_DATA_WIDTH  read data to pad.
REQ-009 mc_data_oe  out  1  pad drive enable.
REQ-010 cfg_regs  out  7*MC_DATA_WIDTH  registers 0x00..0x06; reg n at bits [16n+15:16n].
REQ-011 ctrl_wr_strobe  out  1  one-cycle pulse on each write to 0x03.
REQ-012 cmd_data  out  MC_DATA_WIDTH; cmd_push  out  1; cmd_full  in  1  command FIFO write port.
REQ-013 rsp_data  in  MC_DATA_WIDTH; rsp_pop  out  1; rsp_empty  in  1  response FIFO read port, first-word-fall-through.
REQ-014 bp_active  in  1  state machine busy flag, reported in status.

Function
REQ-015 mc_ce, mc_we and mc_oe SHALL each pass a 2-flop synchronizer, followed by one delay flop for edge detection.
REQ-016 mc_data_oe SHALL equal (!mc_oe && !mc_ce), taken combinationally from the raw pins so the bus is released immediately.
REQ-017 The FSM SHALL have states IDLE, WR_HOLD and RD_HOLD.
REQ-018 IDLE -> WR_HOLD on a detected synced mc_we falling edge while synced mc_ce is low and synced mc_oe is high.
REQ-019 Entering WR_HOLD SHALL perform exactly one write action.
REQ-020 WR_HOLD -> IDLE when synced mc_we is high.
REQ-021 IDLE -> RD_HOLD on a detected synced mc_oe falling edge while synced mc_ce is low and synced mc_we is high.
REQ-022 RD_HOLD -> IDLE when synced mc_oe is high.
REQ-023 If synced mc_we and mc_oe are both low in IDLE, the FSM SHALL take no action and stay in IDLE.
REQ-024 Each write or read action SHALL take effect on the 3rd rising edge after the pin strobe falls; the MCU holds each strobe low for at least 4 clocks.
REQ-025 mc_add and mc_data_in SHALL be sampled on the action edge; the MCU holds them stable for at least 3 clocks before the strobe.
REQ-026 Write to 0x00..0x06: the register SHALL load mc_data_in.
REQ-027 Write to 0x03: ctrl_wr_strobe SHALL pulse for exactly one cycle on the same edge the register loads.
REQ-028 Write to 0x07 with cmd_full low: cmd_data SHALL equal the written value and cmd_push SHALL pulse for one cycle.
REQ-029 Write to 0x07 with cmd_full high: the word SHALL be dropped, no push, and sticky overflow SHALL be set.
REQ-030 Writes to 0x08 and to addresses >= 0x09 SHALL be ignored.
REQ-031 Read results SHALL be latched into mc_data_out on the action edge and held until the next read action.
REQ-032 Read of 0x00..0x06 SHALL return the register value.
REQ-033 Read of 0x07 with rsp_empty low SHALL return rsp_data and pulse rsp_pop for exactly one cycle.
REQ-034 Read of 0x07 with rsp_empty high SHALL return 0x0000, SHALL NOT pop, and SHALL set sticky underflow.
REQ-035 Read of 0x08 SHALL return status {11'b0, bp_active, underflow, overflow, !rsp_empty, cmd_full} sampled on the action edge.
REQ-036 Overflow and underflow SHALL clear on the RD_HOLD -> IDLE transition of a 0x08 read.
REQ-037 A set event on that same edge SHALL take priority over the clear.
REQ-038 Read of addresses >= 0x09 SHALL return 0x0000.
REQ-039 One strobe SHALL produce at most one action, regardless of how long it is held low.

Reset
REQ-040 On reset: FSM = IDLE; cfg_regs, mc_data_out, overflow and underflow = 0; cmd_push, rsp_pop and ctrl_wr_strobe = 0.
REQ-041 On reset, synchronizer and delay flops SHALL load 0 (asserted), so a strobe already low when reset releases produces no action until it has gone high and fallen again.
REQ-042 Reset asserted mid-strobe SHALL abort the transaction with no push or pop.

Verification
REQ-043 Write 0x00=0x00FB, then 0x01=0x0004 -> cfg_regs[15:0]=0x00FB, [31:16]=0x0004; reading back returns the same values.
REQ-044 Write 0x03=0x0088 -> reg3=0x0088 and exactly one ctrl_wr_strobe pulse; a 6-clock strobe yields exactly one pulse.
REQ-045 Writes to 0x07 of 0xFE00, 0x81FF, 0x08AA with cmd_full=0 -> three cmd_push pulses carrying those values in order.
REQ-046 Write 0x07=0x1234 with cmd_full=1 -> no push; read 0x08 returns bit2=1; a second read of 0x08 returns bit2=0.
REQ-047 Read 0x07 with rsp_empty=0, rsp_data=0xBEEF -> mc_data_out=0xBEEF with one rsp_pop pulse; the same read with rsp_empty=1 -> 0x0000, no pop, underflow set.
REQ-048 Hold mc_we low across reset release -> no action; after release and a new low strobe -> exactly one write.
